// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module   : if_stage
// Purpose  : Instruction-fetch stage with the IF/ID pipeline register.
//            Holds the fetch PC, drives the instruction-memory address and
//            registers the fetched word with its PC for the decode stage.
// Revision : 1.0  initial release
// ============================================================================
module if_stage #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] PC_Branch,
  input  logic        PCWrite,
  input  logic        IF_IDWrite,
  input  logic        IF_IDFlush,
  output logic [31:0] IMEM_ADDR,
  input  logic [31:0] IMEM_DATA,
  input  logic        IMEM_VALID,
  output logic [31:0] PC_IF,
  output logic [31:0] PC_ID,
  output logic [31:0] INSTRUCTION_ID,
  output logic        VALID_ID,
  output logic [31:0] FETCH_COUNT
);

  logic [31:0] pc_q, pc_d;
  logic [31:0] pc_id_q, pc_id_d;
  logic [31:0] instr_id_q, instr_id_d;
  logic        valid_id_q, valid_id_d;
  logic [31:0] fetch_count_q, fetch_count_d;

  // Next-state for the fetch PC and the IF/ID register.
  // A redirect squashes the wrong-path word even when the stage is stalled.
  always_comb begin
    pc_d          = pc_q;
    pc_id_d       = pc_id_q;
    instr_id_d    = instr_id_q;
    valid_id_d    = valid_id_q;
    fetch_count_d = fetch_count_q;

    if (PCSrc) begin
      pc_d = {PC_Branch[31:2], 2'b00};
    end else if (PCWrite && IMEM_VALID) begin
      pc_d = pc_q + 32'd4;
    end

    if (PCSrc || IF_IDFlush) begin
      instr_id_d = NOP_INSTR;
      valid_id_d = 1'b0;
      pc_id_d    = pc_q;
    end else if (IF_IDWrite) begin
      pc_id_d = pc_q;
      if (IMEM_VALID) begin
        instr_id_d    = IMEM_DATA;
        valid_id_d    = 1'b1;
        fetch_count_d = fetch_count_q + 32'd1;
      end else begin
        instr_id_d = NOP_INSTR;
        valid_id_d = 1'b0;
      end
    end
  end

  // State registers; reset overrides every other input in the same cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q          <= RESET_PC;
      pc_id_q       <= RESET_PC;
      instr_id_q    <= NOP_INSTR;
      valid_id_q    <= 1'b0;
      fetch_count_q <= 32'd0;
    end else begin
      pc_q          <= pc_d;
      pc_id_q       <= pc_id_d;
      instr_id_q    <= instr_id_d;
      valid_id_q    <= valid_id_d;
      fetch_count_q <= fetch_count_d;
    end
  end

  assign IMEM_ADDR      = {pc_q[31:2], 2'b00};
  assign PC_IF          = pc_q;
  assign PC_ID          = pc_id_q;
  assign INSTRUCTION_ID = instr_id_q;
  assign VALID_ID       = valid_id_q;
  assign FETCH_COUNT    = fetch_count_q;

endmodule
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module   : tb_if_stage
// Purpose  : Directed and randomized bench for if_stage. Two instances share
//            all control inputs: one resets to 0, one to FFFF_FFF8 (wrap).
// Revision : 1.0  initial release
// ============================================================================
module tb_if_stage;

  localparam logic [31:0] NOP = 32'h0000_0013;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, pcsrc, pcw, ifw, flush, ivalid;
  logic [31:0] br, salt;

  logic [31:0] addr   [2];
  logic [31:0] data   [2];
  logic [31:0] pc_if  [2];
  logic [31:0] pc_id  [2];
  logic [31:0] ins_id [2];
  logic        v_id   [2];
  logic [31:0] cnt    [2];

  // Memory contents: the word at address a is (a + 0x100) ^ salt.
  function automatic logic [31:0] mem_word(input logic [31:0] a, input logic [31:0] s);
    return (a + 32'h100) ^ s;
  endfunction

  assign data[0] = mem_word(addr[0], salt);
  assign data[1] = mem_word(addr[1], salt);

  if_stage #(.RESET_PC(32'h0000_0000), .NOP_INSTR(NOP)) dut0 (
    .clk(clk), .reset(reset), .PCSrc(pcsrc), .PC_Branch(br), .PCWrite(pcw),
    .IF_IDWrite(ifw), .IF_IDFlush(flush), .IMEM_ADDR(addr[0]), .IMEM_DATA(data[0]),
    .IMEM_VALID(ivalid), .PC_IF(pc_if[0]), .PC_ID(pc_id[0]),
    .INSTRUCTION_ID(ins_id[0]), .VALID_ID(v_id[0]), .FETCH_COUNT(cnt[0]));

  if_stage #(.RESET_PC(32'hFFFF_FFF8), .NOP_INSTR(NOP)) dut1 (
    .clk(clk), .reset(reset), .PCSrc(pcsrc), .PC_Branch(br), .PCWrite(pcw),
    .IF_IDWrite(ifw), .IF_IDFlush(flush), .IMEM_ADDR(addr[1]), .IMEM_DATA(data[1]),
    .IMEM_VALID(ivalid), .PC_IF(pc_if[1]), .PC_ID(pc_id[1]),
    .INSTRUCTION_ID(ins_id[1]), .VALID_ID(v_id[1]), .FETCH_COUNT(cnt[1]));

  // Reference model state (one copy per instance)
  logic [31:0] m_pc [2], m_pcid [2], m_ins [2], m_cnt [2];
  logic        m_v  [2];

  int vectors = 0;
  int miscompares = 0;

  function automatic logic [31:0] rst_pc(input int i);
    return (i == 0) ? 32'h0000_0000 : 32'hFFFF_FFF8;
  endfunction

  task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, i, obs, exp);
    end
  endtask

  // Model one rising edge from the decode stage's point of view:
  // did a real instruction enter IF/ID, was a bubble written, or was it held?
  task automatic model_edge();
    for (int i = 0; i < 2; i++) begin
      logic [31:0] fetched;
      logic        squash, accepted;
      fetched = mem_word({m_pc[i][31:2], 2'b00}, salt);
      if (reset) begin
        m_pc[i] = rst_pc(i); m_pcid[i] = rst_pc(i);
        m_ins[i] = NOP; m_v[i] = 1'b0; m_cnt[i] = 0;
      end else begin
        squash   = pcsrc || flush;
        accepted = !squash && ifw && ivalid;
        if (squash || (ifw && !ivalid)) begin
          m_pcid[i] = m_pc[i]; m_ins[i] = NOP; m_v[i] = 1'b0;
        end else if (accepted) begin
          m_pcid[i] = m_pc[i]; m_ins[i] = fetched; m_v[i] = 1'b1;
          m_cnt[i]  = m_cnt[i] + 1;
        end
        if (pcsrc)              m_pc[i] = br & 32'hFFFF_FFFC;
        else if (pcw && ivalid) m_pc[i] = m_pc[i] + 4;
      end
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 2; i++) begin
      chk("PC_IF",          i, pc_if[i],  m_pc[i]);
      chk("IMEM_ADDR",      i, addr[i],   m_pc[i] & 32'hFFFF_FFFC);
      chk("PC_ID",          i, pc_id[i],  m_pcid[i]);
      chk("INSTRUCTION_ID", i, ins_id[i], m_ins[i]);
      chk("VALID_ID",       i, {31'd0, v_id[i]}, {31'd0, m_v[i]});
      chk("FETCH_COUNT",    i, cnt[i],    m_cnt[i]);
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check_all();
  endtask

  task automatic set_in(input logic r, input logic s, input logic [31:0] b,
                        input logic pw, input logic iw, input logic fl, input logic iv);
    reset = r; pcsrc = s; br = b; pcw = pw; ifw = iw; flush = fl; ivalid = iv;
  endtask

  initial begin
    salt = 32'd0;
    for (int i = 0; i < 2; i++) begin
      m_pc[i] = 'x; m_pcid[i] = 'x; m_ins[i] = 'x; m_v[i] = 1'bx; m_cnt[i] = 'x;
    end
    // Reset held for two cycles
    set_in(1, 0, 0, 1, 1, 0, 1);
    step(); step();
    chk("rst_PC_IF", 0, pc_if[0], 32'h0);
    chk("rst_PC_IF", 1, pc_if[1], 32'hFFFF_FFF8);
    chk("rst_INSTR", 0, ins_id[0], NOP);

    // Free run, memory returns addr+0x100
    set_in(0, 0, 0, 1, 1, 0, 1);
    step();
    chk("run_INSTR", 0, ins_id[0], 32'h100);
    chk("wrap_PC",   1, pc_if[1], 32'hFFFF_FFFC);
    step();
    chk("run_INSTR", 0, ins_id[0], 32'h104);
    chk("wrap_PC",   1, pc_if[1], 32'h0000_0000);

    // Load-use stall at PC_IF=8 for two cycles
    set_in(0, 0, 0, 0, 0, 0, 1);
    step(); step();
    chk("stall_PC_IF", 0, pc_if[0], 32'h8);
    chk("stall_PC_ID", 0, pc_id[0], 32'h4);
    chk("stall_CNT",   0, cnt[0],   32'd2);
    set_in(0, 0, 0, 1, 1, 0, 1);
    step();
    chk("resume_PC_ID", 0, pc_id[0], 32'h8);
    step();
    chk("four_loads_CNT", 0, cnt[0], 32'd4);

    // Branch redirect at PC_IF=0x10 to unaligned target 0x42
    set_in(0, 1, 32'h42, 1, 1, 0, 1);
    step();
    chk("br_PC_IF",  0, pc_if[0],  32'h40);
    chk("br_PC_ID",  0, pc_id[0],  32'h10);
    chk("br_INSTR",  0, ins_id[0], NOP);
    set_in(0, 0, 0, 1, 1, 0, 1);
    step();
    chk("br_next_PC_ID", 0, pc_id[0], 32'h40);
    chk("br_next_VALID", 0, {31'd0, v_id[0]}, 32'd1);

    // Redirect during stall, also with memory not ready
    set_in(0, 1, 32'h20, 0, 0, 0, 0);
    step();
    chk("brstall_PC_IF", 0, pc_if[0], 32'h20);
    chk("brstall_INSTR", 0, ins_id[0], NOP);

    // Memory not ready for three cycles at 0x20
    set_in(0, 0, 0, 1, 1, 0, 0);
    step(); step(); step();
    chk("nrdy_PC_IF", 0, pc_if[0], 32'h20);
    chk("nrdy_PC_ID", 0, pc_id[0], 32'h20);
    set_in(0, 0, 0, 1, 1, 0, 1);
    step();
    chk("rdy_PC_ID", 0, pc_id[0], 32'h20);
    chk("rdy_INSTR", 0, ins_id[0], 32'h120);

    // Flush wins over IF/ID hold
    set_in(0, 0, 0, 0, 0, 1, 1);
    step();
    chk("flush_INSTR", 0, ins_id[0], NOP);

    // Dropped fetch: PC advances while IF/ID holds
    set_in(0, 0, 0, 1, 0, 0, 1);
    step();

    // Mid-run reset together with a redirect
    set_in(0, 0, 0, 1, 1, 0, 1);
    step(); step();
    set_in(1, 1, 32'h80, 1, 1, 0, 1);
    step();
    chk("mrst_PC_IF", 1, pc_if[1], 32'hFFFF_FFF8);
    chk("mrst_CNT",   0, cnt[0],   32'd0);

    // Randomized phase with non-trivial memory contents
    salt = $urandom;
    for (int n = 0; n < 400; n++) begin
      set_in(($urandom_range(0, 39) == 0), ($urandom_range(0, 7) == 0),
             ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 + $urandom_range(0, 15) : $urandom,
             ($urandom_range(0, 4) != 0), ($urandom_range(0, 4) != 0),
             ($urandom_range(0, 9) == 0), ($urandom_range(0, 3) != 0));
      if ($urandom_range(0, 1) == 1) ifw = pcw;
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage and IF/ID pipeline register: the producer end of the interface the decode stage consumes.
- Holds the program counter and drives the instruction-memory address.
- Registers the fetched word with its PC into PC_ID / INSTRUCTION_ID.
- Honours hazard-unit stalls, branch redirects from EX, and memory not-ready bubbles.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) placed in IF/ID on flush or bubble.

Ports:
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- PCSrc  input  1  branch/jump taken, redirect fetch to PC_Branch.
- PC_Branch  input  32  redirect target from EX.
- PCWrite  input  1  0 = hold PC (load-use stall).
- IF_IDWrite  input  1  0 = hold IF/ID register (stall).
- IF_IDFlush  input  1  1 = replace IF/ID contents with bubble.
- IMEM_ADDR  output  32  instruction memory address (combinational from PC_IF).
- IMEM_DATA  input  32  instruction word at IMEM_ADDR.
- IMEM_VALID  input  1  IMEM_DATA valid this cycle.
- PC_IF  output  32  current fetch PC.
- PC_ID  output  32  PC of the instruction in IF/ID.
- INSTRUCTION_ID  output  32  instruction in IF/ID.
- VALID_ID  output  1  1 = INSTRUCTION_ID is a real fetched instruction.
- FETCH_COUNT  output  32  number of instructions accepted into IF/ID.

Behaviour:
- Clock and reset: single clock, synchronous active-high reset. All registers update only on the rising edge of clk.
- Reset values: PC_IF=RESET_PC; PC_ID=RESET_PC; INSTRUCTION_ID=NOP_INSTR; VALID_ID=0; FETCH_COUNT=0.
- Reset mid-operation overrides all other inputs in the same cycle.
- Memory address: IMEM_ADDR = {PC_IF[31:2],2'b00}. Fetch latency is zero: the word is sampled in the same cycle the address is driven.
- PC next-state priority (highest first):
  - reset: load RESET_PC.
  - PCSrc=1: load {PC_Branch[31:2],2'b00}. Redirect wins over PCWrite=0 and IMEM_VALID=0.
  - PCWrite=0: hold.
  - IMEM_VALID=0: hold and retry the same address.
  - otherwise: PC_IF+4, modulo 2^32. 32'hFFFF_FFFC wraps to 0.
- IF/ID next-state priority (highest first):
  - reset: reset values above.
  - PCSrc=1 or IF_IDFlush=1: INSTRUCTION_ID=NOP_INSTR, VALID_ID=0, PC_ID=PC_IF. The wrong-path word is squashed.
  - IF_IDWrite=0: hold all three fields.
  - IMEM_VALID=0: bubble, i.e. NOP_INSTR, VALID_ID=0, PC_ID=PC_IF.
  - otherwise: INSTRUCTION_ID=IMEM_DATA, PC_ID=PC_IF, VALID_ID=1.
- Stall consistency: the hazard unit drives PCWrite and IF_IDWrite together. If PCWrite=1 and IF_IDWrite=0 with a valid fetch, the PC advances and the fetched word is dropped. This is legal and undetected.
- FETCH_COUNT: increments by 1, wrapping at 2^32, exactly in cycles where the IF/ID register takes the "otherwise" load branch. It never counts bubbles, flushes or holds.
- Simultaneous IF_IDFlush=1 and IF_IDWrite=0: flush wins.
- Simultaneous PCSrc=1 and IMEM_VALID=0: redirect still happens and the bubble is inserted.
- Decode-field alignment: no combinational path from IMEM_DATA to any output except through the IF/ID register. Decode sees fields only from INSTRUCTION_ID: opcode [6:0], rd [11:7], funct3 [14:12], rs1 [19:15], rs2 [24:20], funct7 [31:25].

Test Plan:
- Reset then free run: reset held 2 cycles, IMEM_VALID=1, memory returns addr+0x100. Expect PC_IF 0,4,8,12; INSTRUCTION_ID one cycle behind (0x100,0x104,...); VALID_ID rises 1 cycle after reset release; FETCH_COUNT=4 after 4 loads.
- Load-use stall: PCWrite=IF_IDWrite=0 for 2 cycles at PC_IF=8. Expect PC_IF stays 8; PC_ID=4 and INSTRUCTION_ID=0x104 held; FETCH_COUNT frozen; resume yields PC_ID=8.
- Branch redirect: PCSrc=1, PC_Branch=0x42 at PC_IF=0x10. Expect next PC_IF=0x40; IF/ID = NOP 0x00000013 with VALID_ID=0 and PC_ID=0x10; next cycle PC_ID=0x40, VALID_ID=1.
- Redirect during stall: PCSrc=1, PCWrite=0, IF_IDWrite=0. Expect PC_IF=target and IF/ID flushed to NOP in the same edge.
- Memory not ready: IMEM_VALID=0 for 3 cycles at PC_IF=0x20. Expect PC_IF held at 0x20; 3 bubbles (VALID_ID=0, PC_ID=0x20); FETCH_COUNT unchanged; on IMEM_VALID=1, PC_ID=0x20 valid.
- Wrap and mid-run reset: RESET_PC=32'hFFFF_FFF8. Expect PC_IF sequence FFFF_FFF8, FFFF_FFFC, 0. Asserting reset with PCSrc=1 simultaneously: expect PC_IF=RESET_PC, VALID_ID=0, FETCH_COUNT=0.
